// File: rtl/procb_buf_pkg.sv
// Shared widths and the record layout for the SHA256 processing-bytes buffer.
// Values mirror the sha256.vh constants so existing instantiations keep their widths.
package procb_buf_pkg;

  localparam int MEM_ADDR_MSB  = 15;
  localparam int PROCB_CNT_MSB = 11;
  localparam int PROCB_D_WIDTH = (MEM_ADDR_MSB + 1) + (PROCB_CNT_MSB + 1) + 2;

  typedef struct packed {
    logic [MEM_ADDR_MSB:0]  addr;
    logic [PROCB_CNT_MSB:0] bytes_left;
    logic                   finish_ctx;
    logic                   stop_ctx;
  } procb_rec_t;

  // Index of the highest set bit; 0 for an argument of 0.
  function automatic int msb(input int v);
    int r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (v[i]) r = int'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/procb_ptrs.sv
// Per-thread write / lookahead / commit pointer triple with full and empty flags.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module procb_ptrs #(
  parameter int DEPTH_MSB = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 flush,
  input  logic                 wr_inc,
  input  logic                 look_inc,
  input  logic                 rd_inc,
  output logic [DEPTH_MSB:0]   wr_idx,
  output logic [DEPTH_MSB:0]   look_idx,
  output logic                 full,
  output logic                 lookup_empty,
  output logic                 rd_ok
);

  localparam int PW = DEPTH_MSB + 2;
  localparam logic [PW-1:0] DEPTH = PW'(2 ** (DEPTH_MSB + 1));

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] look_ptr_q, look_ptr_d;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    look_ptr_d = look_ptr_q;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      look_ptr_d = '0;
    end else begin
      if (wr_inc)   wr_ptr_d   = wr_ptr_q + PW'(1);
      if (look_inc) look_ptr_d = look_ptr_q + PW'(1);
      if (rd_inc)   rd_ptr_d   = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      look_ptr_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      look_ptr_q <= look_ptr_d;
    end
  end

  assign wr_idx       = wr_ptr_q[DEPTH_MSB:0];
  assign look_idx     = look_ptr_q[DEPTH_MSB:0];
  assign full         = (wr_ptr_q - rd_ptr_q) == DEPTH;
  assign lookup_empty = (look_ptr_q == wr_ptr_q);
  assign rd_ok        = (rd_ptr_q != look_ptr_q);

endmodule

// File: rtl/procb_buf.sv
// Multi-thread record queue: one write port, a lookahead read pointer and a
// separate commit pointer per thread, backed by one distributed RAM.
module procb_buf
  import procb_buf_pkg::*;
#(
  parameter int N_CORES       = 3,
  parameter int N_THREADS     = 2 * N_CORES,
  parameter int N_THREADS_MSB = msb(N_THREADS - 1),
  parameter int DEPTH_MSB     = 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [N_THREADS_MSB:0]   wr_thread_num,
  input  logic                     wr_en,
  input  logic [PROCB_D_WIDTH-1:0] din,
  output logic                     full,
  input  logic [N_THREADS_MSB:0]   rd_thread_num,
  input  logic                     lookup_en,
  input  logic                     rd_en,
  input  logic                     rd_rst,
  output logic                     lookup_empty,
  output logic [PROCB_D_WIDTH-1:0] dout,
  output logic                     err
);

  localparam int TW = N_THREADS_MSB + 1;
  localparam int IW = DEPTH_MSB + 1;

  logic [N_THREADS-1:0] wr_inc_v, look_inc_v, rd_inc_v, flush_v;
  logic [N_THREADS-1:0] full_v, empty_v, rd_ok_v;
  logic [IW-1:0]        wr_idx_a   [N_THREADS];
  logic [IW-1:0]        look_idx_a [N_THREADS];

  logic [PROCB_D_WIDTH-1:0] mem_q [N_THREADS * (2 ** IW)];

  logic          wr_sel_ok, rd_sel_ok, wr_full, rd_empty, rd_ok, mem_we;
  logic [IW-1:0] wr_idx, look_idx;
  logic          err_q, err_d;

  for (genvar t = 0; t < N_THREADS; t++) begin : g_ptrs
    procb_ptrs #(.DEPTH_MSB(DEPTH_MSB)) u_ptrs (
      .CLK          (CLK),
      .RST          (RST),
      .flush        (flush_v[t]),
      .wr_inc       (wr_inc_v[t]),
      .look_inc     (look_inc_v[t]),
      .rd_inc       (rd_inc_v[t]),
      .wr_idx       (wr_idx_a[t]),
      .look_idx     (look_idx_a[t]),
      .full         (full_v[t]),
      .lookup_empty (empty_v[t]),
      .rd_ok        (rd_ok_v[t])
    );
  end

  // Thread-number values beyond N_THREADS select nothing: reads look empty, writes vanish.
  always_comb begin
    wr_sel_ok  = 1'b0;
    rd_sel_ok  = 1'b0;
    wr_full    = 1'b0;
    rd_empty   = 1'b1;
    rd_ok      = 1'b0;
    wr_idx     = '0;
    look_idx   = '0;
    flush_v    = '0;
    wr_inc_v   = '0;
    look_inc_v = '0;
    rd_inc_v   = '0;
    for (int unsigned t = 0; t < N_THREADS; t++) begin
      if (wr_thread_num == TW'(t)) begin
        wr_sel_ok = 1'b1;
        wr_full   = full_v[t];
        wr_idx    = wr_idx_a[t];
      end
      if (rd_thread_num == TW'(t)) begin
        rd_sel_ok = 1'b1;
        rd_empty  = empty_v[t];
        rd_ok     = rd_ok_v[t];
        look_idx  = look_idx_a[t];
      end
      flush_v[t]    = rd_rst & (rd_thread_num == TW'(t));
      wr_inc_v[t]   = wr_en & (wr_thread_num == TW'(t)) & ~full_v[t] & ~flush_v[t];
      look_inc_v[t] = lookup_en & (rd_thread_num == TW'(t)) & ~empty_v[t] & ~flush_v[t];
      rd_inc_v[t]   = rd_en & (rd_thread_num == TW'(t)) & rd_ok_v[t] & ~flush_v[t];
    end
    mem_we = |wr_inc_v;
  end

  // A flush on the write thread swallows a write-when-full without flagging it.
  always_comb begin
    err_d = err_q;
    if (wr_en & wr_sel_ok & wr_full &
        ~(rd_rst & rd_sel_ok & (rd_thread_num == wr_thread_num)))
      err_d = 1'b1;
    if (rd_en & rd_sel_ok & ~rd_rst & ~rd_ok)
      err_d = 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  always_ff @(posedge CLK) begin
    if (mem_we) mem_q[{wr_thread_num, wr_idx}] <= din;
  end

  assign full         = wr_full;
  assign lookup_empty = rd_empty;
  assign dout         = rd_sel_ok ? mem_q[{rd_thread_num, look_idx}] : '0;
  assign err          = err_q;

endmodule

// File: tb/tb_procb_buf.sv
// Self-checking bench for procb_buf: directed vector table plus a queue
// scoreboard for interleaved multi-thread traffic and a mid-run reset.
module tb_procb_buf;
  import procb_buf_pkg::*;

  localparam int DW = PROCB_D_WIDTH;

  logic          CLK = 1'b0;
  logic          RST;
  logic [2:0]    wr_thread_num, rd_thread_num;
  logic          wr_en, lookup_en, rd_en, rd_rst;
  logic [DW-1:0] din, dout;
  logic          full, lookup_empty, err;

  procb_buf #(.N_CORES(3), .DEPTH_MSB(1)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .wr_thread_num (wr_thread_num),
    .wr_en         (wr_en),
    .din           (din),
    .full          (full),
    .rd_thread_num (rd_thread_num),
    .lookup_en     (lookup_en),
    .rd_en         (rd_en),
    .rd_rst        (rd_rst),
    .lookup_empty  (lookup_empty),
    .dout          (dout),
    .err           (err)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit            pre_rst;
    bit            we;
    logic [2:0]    wt;
    logic [DW-1:0] d;
    bit            lk, rd, rr;
    logic [2:0]    rt;
    bit            e_full, e_le, c_dout;
    logic [DW-1:0] e_dout;
    bit            e_err;
  } vec_t;

  vec_t          tbl[$];
  logic [DW-1:0] q3[$], q5[$];
  int            occ[6], unl[6], pend[6];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mkd(input int k);
    procb_rec_t r;
    r.addr       = (MEM_ADDR_MSB + 1)'(32'h1000 + k * 16);
    r.bytes_left = (PROCB_CNT_MSB + 1)'(k * 3 + 1);
    r.finish_ctx = k[0];
    r.stop_ctx   = k[1];
    return r;
  endfunction

  function automatic vec_t mk(input bit pre, input bit we, input int wt, input logic [DW-1:0] d,
                              input bit lk, input bit rd, input bit rr, input int rt,
                              input bit ef, input bit ele, input bit cd, input logic [DW-1:0] ed,
                              input bit eerr);
    vec_t v;
    v.pre_rst = pre; v.we = we; v.wt = 3'(wt); v.d = d;
    v.lk = lk; v.rd = rd; v.rr = rr; v.rt = 3'(rt);
    v.e_full = ef; v.e_le = ele; v.c_dout = cd; v.e_dout = ed; v.e_err = eerr;
    return v;
  endfunction

  task automatic drive(input bit we, input logic [2:0] wt, input logic [DW-1:0] d,
                       input bit lk, input bit rd, input bit rr, input logic [2:0] rt);
    @(posedge CLK);
    #1;
    wr_en = we; wr_thread_num = wt; din = d;
    lookup_en = lk; rd_en = rd; rd_rst = rr; rd_thread_num = rt;
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #2;
    wr_en = 0; lookup_en = 0; rd_en = 0; rd_rst = 0; din = '0;
    RST = 1'b1;
    #4;
    RST = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wt_i;
    bit we, lk, rd;
    logic [DW-1:0] d;

    RST = 1'b1;
    wr_en = 0; lookup_en = 0; rd_en = 0; rd_rst = 0; din = '0;
    wr_thread_num = 3'd0; rd_thread_num = 3'd0;
    #12;
    chk("rst_full", full, 1'b0);
    chk("rst_lookup_empty", lookup_empty, 1'b1);
    chk("rst_err", err, 1'b0);
    RST = 1'b0;

    // Three records on thread 2, looked up in order.
    tbl.push_back(mk(1, 1, 2, mkd(1), 0, 0, 0, 2, 0, 1, 0, '0, 0));
    tbl.push_back(mk(0, 1, 2, mkd(2), 0, 0, 0, 2, 0, 0, 1, mkd(1), 0));
    tbl.push_back(mk(0, 1, 2, mkd(3), 0, 0, 0, 2, 0, 0, 1, mkd(1), 0));
    tbl.push_back(mk(0, 0, 2, '0, 1, 0, 0, 2, 0, 0, 1, mkd(1), 0));
    tbl.push_back(mk(0, 0, 2, '0, 1, 0, 0, 2, 0, 0, 1, mkd(2), 0));
    tbl.push_back(mk(0, 0, 2, '0, 1, 0, 0, 2, 0, 0, 1, mkd(3), 0));
    tbl.push_back(mk(0, 0, 2, '0, 0, 0, 0, 2, 0, 1, 0, '0, 0));
    // Fill thread 0, overflow, then lookup + commit releases full.
    tbl.push_back(mk(0, 1, 0, mkd(10), 0, 0, 0, 0, 0, 1, 0, '0, 0));
    tbl.push_back(mk(0, 1, 0, mkd(11), 0, 0, 0, 0, 0, 0, 1, mkd(10), 0));
    tbl.push_back(mk(0, 1, 0, mkd(12), 0, 0, 0, 0, 0, 0, 1, mkd(10), 0));
    tbl.push_back(mk(0, 1, 0, mkd(13), 0, 0, 0, 0, 0, 0, 1, mkd(10), 0));
    tbl.push_back(mk(0, 1, 0, mkd(14), 0, 0, 0, 0, 1, 0, 1, mkd(10), 0));
    tbl.push_back(mk(0, 0, 0, '0, 1, 0, 0, 0, 1, 0, 1, mkd(10), 1));
    tbl.push_back(mk(0, 0, 0, '0, 0, 1, 0, 0, 1, 0, 1, mkd(11), 1));
    tbl.push_back(mk(0, 0, 0, '0, 0, 0, 0, 0, 0, 0, 1, mkd(11), 1));
    // Thread 1: lookup and commit together with nothing looked up yet.
    tbl.push_back(mk(1, 1, 1, mkd(20), 0, 0, 0, 1, 0, 1, 0, '0, 0));
    tbl.push_back(mk(0, 1, 1, mkd(21), 0, 0, 0, 1, 0, 0, 1, mkd(20), 0));
    tbl.push_back(mk(0, 0, 1, '0, 1, 1, 0, 1, 0, 0, 1, mkd(20), 0));
    tbl.push_back(mk(0, 0, 1, '0, 0, 0, 0, 1, 0, 0, 1, mkd(21), 1));
    tbl.push_back(mk(0, 0, 1, '0, 0, 1, 0, 1, 0, 0, 1, mkd(21), 1));
    tbl.push_back(mk(0, 0, 1, '0, 1, 0, 0, 1, 0, 0, 1, mkd(21), 1));
    tbl.push_back(mk(0, 0, 1, '0, 0, 0, 0, 1, 0, 1, 0, '0, 1));
    // Thread 4: flush with a simultaneous write; the write is lost.
    tbl.push_back(mk(1, 1, 4, mkd(30), 0, 0, 0, 4, 0, 1, 0, '0, 0));
    tbl.push_back(mk(0, 1, 4, mkd(31), 0, 0, 0, 4, 0, 0, 1, mkd(30), 0));
    tbl.push_back(mk(0, 1, 4, mkd(32), 0, 0, 0, 4, 0, 0, 1, mkd(30), 0));
    tbl.push_back(mk(0, 1, 4, mkd(33), 0, 0, 1, 4, 0, 0, 1, mkd(30), 0));
    tbl.push_back(mk(0, 0, 4, '0, 0, 0, 0, 4, 0, 1, 0, '0, 0));
    tbl.push_back(mk(0, 1, 4, mkd(34), 0, 0, 0, 4, 0, 1, 0, '0, 0));
    tbl.push_back(mk(0, 0, 4, '0, 0, 0, 0, 4, 0, 0, 1, mkd(34), 0));

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].pre_rst) do_reset();
      drive(tbl[i].we, tbl[i].wt, tbl[i].d, tbl[i].lk, tbl[i].rd, tbl[i].rr, tbl[i].rt);
      @(negedge CLK);
      chk($sformatf("v%0d_full", i), full, tbl[i].e_full);
      chk($sformatf("v%0d_lookup_empty", i), lookup_empty, tbl[i].e_le);
      chk($sformatf("v%0d_err", i), err, tbl[i].e_err);
      if (tbl[i].c_dout) chk($sformatf("v%0d_dout", i), dout, tbl[i].e_dout);
    end

    // Interleaved writes to threads 3/5 with lookups and commits on thread 3.
    do_reset();
    for (int t = 0; t < 6; t++) begin occ[t] = 0; unl[t] = 0; pend[t] = 0; end
    for (int c = 0; c < 20; c++) begin
      wt_i = (c % 2 == 1) ? 5 : 3;
      we   = occ[wt_i] < 4;
      lk   = unl[3] > 0;
      rd   = pend[3] > 0;
      d    = mkd(100 + c);
      drive(we, 3'(wt_i), d, lk, rd, 1'b0, 3'd3);
      if (we) begin
        if (wt_i == 3) q3.push_back(d);
        else           q5.push_back(d);
      end
      @(negedge CLK);
      chk($sformatf("sb%0d_full", c), full, (occ[wt_i] == 4));
      chk($sformatf("sb%0d_lookup_empty", c), lookup_empty, (unl[3] == 0));
      chk($sformatf("sb%0d_err", c), err, 1'b0);
      if (lk) chk($sformatf("sb%0d_dout_t3", c), dout, q3.pop_front());
      if (we) begin occ[wt_i]++; unl[wt_i]++; end
      if (rd) begin pend[3]--; occ[3]--; end
      if (lk) begin unl[3]--; pend[3]++; end
    end
    for (int k = 0; k < 8 && q5.size() > 0; k++) begin
      drive(1'b0, 3'd5, '0, 1'b1, 1'b0, 1'b0, 3'd5);
      @(negedge CLK);
      chk($sformatf("drain%0d_lookup_empty", k), lookup_empty, 1'b0);
      chk($sformatf("drain%0d_dout_t5", k), dout, q5.pop_front());
    end
    chk("drain_left", 32'(q5.size()), '0);
    drive(1'b0, 3'd5, '0, 1'b0, 1'b0, 1'b0, 3'd5);
    @(negedge CLK);
    chk("drain_end_lookup_empty", lookup_empty, 1'b1);
    chk("drain_end_err", err, 1'b0);

    // Asynchronous reset while every thread holds records and err is set.
    do_reset();
    for (int t = 0; t < 6; t++) begin
      drive(1'b1, 3'(t), mkd(150 + 2 * t), 1'b0, 1'b0, 1'b0, 3'(t));
      drive(1'b1, 3'(t), mkd(151 + 2 * t), 1'b0, 1'b0, 1'b0, 3'(t));
    end
    drive(1'b0, 3'd0, '0, 1'b0, 1'b1, 1'b0, 3'd0);
    drive(1'b0, 3'd3, '0, 1'b0, 1'b0, 1'b0, 3'd3);
    @(negedge CLK);
    chk("prerst_err", err, 1'b1);
    chk("prerst_lookup_empty_t3", lookup_empty, 1'b0);
    chk("prerst_dout_t3", dout, mkd(156));
    #1;
    RST = 1'b1;
    #2;
    chk("inrst_err", err, 1'b0);
    #1;
    RST = 1'b0;
    for (int t = 0; t < 6; t++) begin
      drive(1'b0, 3'(t), '0, 1'b0, 1'b0, 1'b0, 3'(t));
      @(negedge CLK);
      chk($sformatf("postrst_t%0d_lookup_empty", t), lookup_empty, 1'b1);
      chk($sformatf("postrst_t%0d_full", t), full, 1'b0);
      chk($sformatf("postrst_t%0d_err", t), err, 1'b0);
    end
    drive(1'b1, 3'd0, mkd(200), 1'b0, 1'b0, 1'b0, 3'd0);
    drive(1'b0, 3'd0, '0, 1'b0, 1'b0, 1'b0, 3'd0);
    @(negedge CLK);
    chk("postrst_wr_lookup_empty", lookup_empty, 1'b0);
    chk("postrst_wr_dout", dout, mkd(200));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
